// File: rtl/state_watcher.sv
// rtl/state_watcher.sv - byte-strobe watcher: latches received bytes into state while armed.
// Optional re-arm from LOCKED on a MODULE_ID byte is enabled by macro STATE_WATCHER_REARM_EN.
module state_watcher #(
    parameter logic [7:0] MODULE_ID   = 8'h15,
    parameter logic [7:0] RESET_STATE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_ready,
    input  logic [7:0] Rx_data,
    output logic [7:0] state,
    output logic       state_change,
    output logic       armed
);

    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } watch_e;

    watch_e     watch_q, watch_d;
    logic [7:0] state_q, state_d;
    logic       state_change_q, state_change_d;
    logic       rx_prev_q, rx_prev_d;
    logic       accept;

    always_comb begin
        accept         = Rx_ready & ~rx_prev_q;
        rx_prev_d      = Rx_ready;
        watch_d        = watch_q;
        state_d        = state_q;
        state_change_d = 1'b0;
        if (accept) begin
            case (watch_q)
                ARMED: begin
                    state_d        = Rx_data;
                    state_change_d = 1'b1;
                    watch_d        = (Rx_data == MODULE_ID) ? ARMED : LOCKED;
                end
                LOCKED: begin
`ifdef STATE_WATCHER_REARM_EN
                    // Re-arm only; the ID byte itself is not written to state.
                    if (Rx_data == MODULE_ID) begin
                        watch_d = ARMED;
                    end
`else
                    watch_d = LOCKED;
`endif
                end
                default: watch_d = ARMED;
            endcase
        end
    end

    // Previous strobe resets to 1 so a strobe held high across reset is not taken as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            watch_q        <= ARMED;
            state_q        <= RESET_STATE;
            state_change_q <= 1'b0;
            rx_prev_q      <= 1'b1;
        end else begin
            watch_q        <= watch_d;
            state_q        <= state_d;
            state_change_q <= state_change_d;
            rx_prev_q      <= rx_prev_d;
        end
    end

    assign state        = state_q;
    assign state_change = state_change_q;
    assign armed        = (watch_q == ARMED);

endmodule

// File: tb/tb_state_watcher.sv
// tb/tb_state_watcher.sv - directed scoreboard bench for state_watcher.
module tb_state_watcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       Rx_ready;
    logic [7:0] Rx_data;
    logic [7:0] state;
    logic       state_change;
    logic       armed;

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         base;
    logic       prev_sc = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    state_watcher dut (
        .clk          (clk),
        .reset        (reset),
        .Rx_ready     (Rx_ready),
        .Rx_data      (Rx_data),
        .state        (state),
        .state_change (state_change),
        .armed        (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every state_change pulse must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (state_change === 1'b1) begin
            pulses++;
            check("sc_double", {31'd0, prev_sc}, 32'd0);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", {24'd0, state}, 32'hFFFF_FFFF);
            end else begin
                exp_b = exp_q.pop_front();
                check("sb_state", {24'd0, state}, {24'd0, exp_b});
            end
        end
        prev_sc = state_change;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] d);
        @(negedge clk);
        Rx_data  = d;
        Rx_ready = 1'b1;
        @(negedge clk);
        Rx_ready = 1'b0;
        Rx_data  = 8'($urandom);
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        Rx_ready = 1'b0;
        Rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: first byte after reset is written and locks
        check("rst_state", {24'd0, state}, 32'h00);
        check("rst_armed", {31'd0, armed}, 32'd1);
        check("rst_sc", {31'd0, state_change}, 32'd0);
        base = pulses;
        exp_q.push_back(8'hB6);
        strobe(8'hB6);
        check("s1_state", {24'd0, state}, 32'hB6);
        check("s1_armed", {31'd0, armed}, 32'd0);
        check("s1_sc_low", {31'd0, state_change}, 32'd0);
        check("s1_pulses", pulses - base, 32'd1);

        // 2: locked ignores bytes
        strobe(8'hA7);
        check("s2_state", {24'd0, state}, 32'hB6);
        check("s2_armed", {31'd0, armed}, 32'd0);
        check("s2_pulses", pulses - base, 32'd1);

        // 3: reset from LOCKED re-arms
        do_reset();
        check("s3_rst_state", {24'd0, state}, 32'h00);
        check("s3_rst_armed", {31'd0, armed}, 32'd1);
        base = pulses;
        exp_q.push_back(8'h7A);
        strobe(8'h7A);
        check("s3_state", {24'd0, state}, 32'h7A);
        check("s3_pulses", pulses - base, 32'd1);

        // 4: MODULE_ID keeps watcher armed
        do_reset();
        base = pulses;
        exp_q.push_back(8'h15);
        strobe(8'h15);
        check("s4_state_id", {24'd0, state}, 32'h15);
        check("s4_armed_id", {31'd0, armed}, 32'd1);
        exp_q.push_back(8'h15);
        strobe(8'h15);
        check("s4_same_val", {24'd0, state}, 32'h15);
        exp_q.push_back(8'h3C);
        strobe(8'h3C);
        check("s4_state", {24'd0, state}, 32'h3C);
        check("s4_armed", {31'd0, armed}, 32'd0);
        check("s4_pulses", pulses - base, 32'd3);

        // 5: held strobe writes once; data changes while held are ignored
        do_reset();
        base = pulses;
        exp_q.push_back(8'h22);
        @(negedge clk);
        Rx_data  = 8'h22;
        Rx_ready = 1'b1;
        @(negedge clk);
        Rx_data = 8'h55;
        repeat (4) @(negedge clk);
        Rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("s5_state", {24'd0, state}, 32'h22);
        check("s5_pulses", pulses - base, 32'd1);

        // 5b: strobe rising together with reset and held across it is dropped
        base = pulses;
        @(negedge clk);
        reset    = 1'b1;
        Rx_ready = 1'b1;
        Rx_data  = 8'h99;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        Rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("s5b_state", {24'd0, state}, 32'h00);
        check("s5b_armed", {31'd0, armed}, 32'd1);
        check("s5b_pulses", pulses - base, 32'd0);

        // 6: ID byte in LOCKED (re-arm only when enabled)
        do_reset();
        base = pulses;
        exp_q.push_back(8'h3C);
        strobe(8'h3C);
        strobe(8'h15);
        check("s6_state_mid", {24'd0, state}, 32'h3C);
`ifdef STATE_WATCHER_REARM_EN
        check("s6_armed_mid", {31'd0, armed}, 32'd1);
        exp_q.push_back(8'h44);
        strobe(8'h44);
        check("s6_state", {24'd0, state}, 32'h44);
        check("s6_pulses", pulses - base, 32'd2);
`else
        check("s6_armed_mid", {31'd0, armed}, 32'd0);
        strobe(8'h44);
        check("s6_state", {24'd0, state}, 32'h3C);
        check("s6_pulses", pulses - base, 32'd1);
`endif
        check("s6_armed", {31'd0, armed}, 32'd0);

        repeat (2) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/state_watcher.md
STATE_WATCHER -- requirements
Module: state_watcher

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  MODULE_ID    8'h15  byte value that keeps the watcher armed after it is latched
  RESET_STATE  8'h00  value loaded into state by reset
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
  clk           input   1  single clock; all logic on rising edge
  reset         input   1  synchronous, active-high reset
  Rx_ready      input   1  receive-byte strobe from the UART receiver (level, clk domain)
  Rx_data       input   8  received byte, valid while Rx_ready=1
  state         output  8  registered state value
  state_change  output  1  one-cycle pulse: state was written this cycle
  armed         output  1  1 = next received byte will be latched into state
REQ-003 There SHALL be one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 A byte SHALL be accepted only on a Rx_ready rising edge, defined as Rx_ready=1 at a clk edge while the registered previous Rx_ready value is 0; holding Rx_ready high SHALL accept exactly one byte.
REQ-005 The watcher SHALL have two states, ARMED and LOCKED; armed SHALL be 1 exactly in ARMED.
REQ-006 ARMED + accepted byte: state<=Rx_data at that edge, and state_change=1 for the following cycle.
REQ-007 ARMED + accepted byte equal to MODULE_ID: the watcher SHALL stay ARMED.
REQ-008 ARMED + accepted byte not equal to MODULE_ID: the watcher SHALL go to LOCKED.
REQ-009 LOCKED + accepted byte: state SHALL NOT change and state_change SHALL stay 0, except as in REQ-016.
REQ-010 Latency from the accepting edge to the updated state and the state_change pulse SHALL be one clk edge, with both outputs registered.
REQ-011 state_change SHALL pulse on every write, even if the new value equals the old one, and SHALL never be high two cycles in a row for one byte.
REQ-012 Rx_data SHALL be sampled only at the accepting edge; changes at any other time SHALL be ignored.

Reset
REQ-013 While reset=1 at a clk edge, outputs SHALL be set as follows:
  - state=RESET_STATE
  - state_change=0
  - watcher ARMED (armed=1)
  - registered previous Rx_ready=1, so a strobe held high across reset is not accepted
REQ-014 Reset SHALL take priority over a simultaneous Rx_ready rising edge, and that byte SHALL be dropped.
REQ-015 Reset asserted in LOCKED SHALL return the watcher to ARMED on the same edge.

Configuration
REQ-016 With macro STATE_WATCHER_REARM_EN defined, a byte accepted in LOCKED and equal to MODULE_ID SHALL re-arm the watcher: state and state_change stay unchanged, and the next accepted byte is latched per REQ-006..008.
REQ-017 Without STATE_WATCHER_REARM_EN, LOCKED SHALL be left only by reset.

Verification
REQ-018 The bench SHALL cover these directed scenarios, each stimulus -> required response:
  1. Reset, then Rx_data=8'hB6 with Rx_ready 0->1 -> state=8'hB6, a one-cycle state_change pulse, armed=0.
  2. Continue with Rx_data=8'hA7 and a strobe -> state stays 8'hB6, no pulse, armed=0.
  3. Pulse reset, then Rx_data=8'h7A with a strobe -> state=8'h00 after reset, then 8'h7A with one pulse.
  4. Reset, then strobes with 8'h15 followed by 8'h3C -> state 8'h15 (armed=1), then 8'h3C (armed=0), two pulses total.
  5. Rx_ready held high for 5 cycles with 8'h22 -> exactly one write and one pulse; a strobe held across reset produces no write.
  6. With STATE_WATCHER_REARM_EN, in LOCKED send 8'h15 then 8'h44 -> state=8'h44; without the macro, state is unchanged.
